instr_fetch: RTL and testbench

Program sequencer that feeds the processor datapath's `instr` input. It holds a 16-word × 8-bit program memory, which is loadable while stopped. It runs a program counter under a small FSM and emits one registered instruction per non-stalled cycle. It consumes the processor's `zero_flag` for conditional jumps and recognises a halt opcode.

---
 rtl/instr_fetch.sv | 126 ++++++++++++
 tb/tb_instr_fetch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: program sequencer with a 16 x 8 loadable program memory, a PC
// run by an IDLE/RUN/HALT FSM, and one registered instruction per non-stalled
// cycle. Optional JMP/JZ decoding is enabled by defining FETCH_BRANCH_EN;
// without it those opcodes issue as ordinary instructions.
module instr_fetch #(
   parameter logic [3:0] START_PC = 4'd0,
   parameter logic [7:0] NOP_WORD = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stall,
   input  logic       prog_we,
   input  logic [3:0] prog_addr,
   input  logic [7:0] prog_data,
   input  logic       zero_flag,
   output logic [7:0] instr,
   output logic       instr_valid,
   output logic [3:0] pc,
   output logic       halted
);

   localparam logic [3:0] OpHalt = 4'hF;
`ifdef FETCH_BRANCH_EN
   localparam logic [3:0] OpJmp  = 4'hE;
   localparam logic [3:0] OpJz   = 4'hD;
`endif

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

   state_e     state_q, state_d;
   logic [3:0] pc_q, pc_d;
   logic [7:0] instr_q, instr_d;
   logic       valid_q, valid_d;
   logic [7:0] fetch_word;

   // Not cleared by reset; zero-initialised for simulation only.
   logic [7:0] mem_q [16] = '{default: 8'h00};

`ifndef FETCH_BRANCH_EN
   // Flag is only needed by JZ.
   logic unused_zero_flag;
   assign unused_zero_flag = zero_flag;
`endif

   assign fetch_word = mem_q[pc_q];

   // Program memory write port, only open while the sequencer is not running.
   always_ff @(posedge clk) begin
      if (!rst && prog_we && (state_q != StRun)) begin
         mem_q[prog_addr] <= prog_data;
      end
   end

   // State, PC and issued-instruction registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         pc_q    <= 4'd0;
         instr_q <= NOP_WORD;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   // Next-state, PC update and opcode decode; stall simply holds every register.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      unique case (state_q)
         StIdle, StHalt: begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            if (start) begin
               state_d = StRun;
               pc_d    = START_PC;
            end
         end
         StRun: begin
            if (!stall) begin
               case (fetch_word[7:4])
                  OpHalt: begin
                     state_d = StHalt;
                     instr_d = NOP_WORD;
                     valid_d = 1'b0;
                  end
`ifdef FETCH_BRANCH_EN
                  OpJmp: begin
                     pc_d    = fetch_word[3:0];
                     instr_d = NOP_WORD;
                     valid_d = 1'b0;
                  end
                  OpJz: begin
                     pc_d    = zero_flag ? fetch_word[3:0] : pc_q + 4'd1;
                     instr_d = NOP_WORD;
                     valid_d = 1'b0;
                  end
`endif
                  default: begin
                     instr_d = fetch_word;
                     valid_d = 1'b1;
                     pc_d    = pc_q + 4'd1;
                  end
               endcase
            end
         end
         default: begin
            state_d = StIdle;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
         end
      endcase
   end

   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign halted      = (state_q == StHalt);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; expectations follow FETCH_BRANCH_EN.
module tb_instr_fetch;

   logic       clk = 1'b0;
   logic       rst, start, stall, prog_we, zero_flag;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;
   logic [7:0] instr;
   logic       instr_valid;
   logic [3:0] pc;
   logic       halted;

   int checks = 0;
   int errors = 0;

   instr_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stall       (stall),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .zero_flag   (zero_flag),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [7:0] e_instr, input logic e_valid,
                             input logic [3:0] e_pc, input logic e_halted);
      checks++;
      assert (instr === e_instr) else begin
         errors++;
         $error("FAIL %s instr observed %h expected %h", tag, instr, e_instr);
      end
      checks++;
      assert (instr_valid === e_valid) else begin
         errors++;
         $error("FAIL %s instr_valid observed %b expected %b", tag, instr_valid, e_valid);
      end
      checks++;
      assert (pc === e_pc) else begin
         errors++;
         $error("FAIL %s pc observed %h expected %h", tag, pc, e_pc);
      end
      checks++;
      assert (halted === e_halted) else begin
         errors++;
         $error("FAIL %s halted observed %b expected %b", tag, halted, e_halted);
      end
   endtask

   task automatic load(input logic [3:0] a, input logic [7:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      step();
      prog_we   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stall = 1'b0; prog_we = 1'b0; zero_flag = 1'b0;
      prog_addr = 4'd0; prog_data = 8'h00;

      // Reset then idle
      do_reset();
      expect_out("reset", 8'h00, 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         expect_out("idle", 8'h00, 1'b0, 4'h0, 1'b0);
      end
      for (int i = 0; i < 16; i++) load(i[3:0], 8'h00);

      // Straight-line program ending in HALT
      load(4'h0, 8'h10); load(4'h1, 8'h20); load(4'h2, 8'hF0);
      start = 1'b1; step(); start = 1'b0;
      expect_out("seq_start", 8'h00, 1'b0, 4'h0, 1'b0);
      step(); expect_out("seq_i0", 8'h10, 1'b1, 4'h1, 1'b0);
      step(); expect_out("seq_i1", 8'h20, 1'b1, 4'h2, 1'b0);
      step(); expect_out("seq_halt", 8'h00, 1'b0, 4'h2, 1'b1);
      step(); expect_out("seq_halt_hold", 8'h00, 1'b0, 4'h2, 1'b1);

      // JMP loop (mem[2] still F0)
      load(4'h0, 8'h10); load(4'h1, 8'hE0);
      start = 1'b1; step(); start = 1'b0;
      expect_out("jmp_start", 8'h00, 1'b0, 4'h0, 1'b0);
`ifdef FETCH_BRANCH_EN
      for (int i = 0; i < 3; i++) begin
         step(); expect_out("jmp_issue", 8'h10, 1'b1, 4'h1, 1'b0);
         step(); expect_out("jmp_bubble", 8'h00, 1'b0, 4'h0, 1'b0);
      end
`else
      step(); expect_out("jmp_i0", 8'h10, 1'b1, 4'h1, 1'b0);
      step(); expect_out("jmp_as_instr", 8'hE0, 1'b1, 4'h2, 1'b0);
      step(); expect_out("jmp_halt", 8'h00, 1'b0, 4'h2, 1'b1);
`endif
      // Reset wins over a simultaneous start, stall and write
      rst = 1'b1; start = 1'b1; stall = 1'b1; prog_we = 1'b1;
      prog_addr = 4'h0; prog_data = 8'hF0;
      step();
      rst = 1'b0; start = 1'b0; stall = 1'b0; prog_we = 1'b0;
      expect_out("rst_override", 8'h00, 1'b0, 4'h0, 1'b0);
      step(); expect_out("rst_stays_idle", 8'h00, 1'b0, 4'h0, 1'b0);

      // JZ taken / not taken (mem[2] still F0)
      load(4'h0, 8'hD3); load(4'h1, 8'h10); load(4'h3, 8'h20); load(4'h4, 8'hF0);
      zero_flag = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      expect_out("jz1_start", 8'h00, 1'b0, 4'h0, 1'b0);
`ifdef FETCH_BRANCH_EN
      step(); expect_out("jz1_bubble", 8'h00, 1'b0, 4'h3, 1'b0);
      step(); expect_out("jz1_target", 8'h20, 1'b1, 4'h4, 1'b0);
      step(); expect_out("jz1_halt", 8'h00, 1'b0, 4'h4, 1'b1);
`else
      step(); expect_out("jz1_as_instr", 8'hD3, 1'b1, 4'h1, 1'b0);
      step(); expect_out("jz1_i1", 8'h10, 1'b1, 4'h2, 1'b0);
      step(); expect_out("jz1_halt", 8'h00, 1'b0, 4'h2, 1'b1);
`endif
      zero_flag = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      expect_out("jz0_start", 8'h00, 1'b0, 4'h0, 1'b0);
`ifdef FETCH_BRANCH_EN
      step(); expect_out("jz0_bubble", 8'h00, 1'b0, 4'h1, 1'b0);
`else
      step(); expect_out("jz0_as_instr", 8'hD3, 1'b1, 4'h1, 1'b0);
`endif
      step(); expect_out("jz0_fall", 8'h10, 1'b1, 4'h2, 1'b0);
      step(); expect_out("jz0_halt", 8'h00, 1'b0, 4'h2, 1'b1);

      // Stall, and writes ignored while running
      load(4'h0, 8'h10); load(4'h1, 8'h20); load(4'h2, 8'h30); load(4'h3, 8'h40);
      load(4'h4, 8'hF0);
      start = 1'b1; step(); start = 1'b0;
      step(); expect_out("stl_i0", 8'h10, 1'b1, 4'h1, 1'b0);
      stall = 1'b1; prog_we = 1'b1; prog_addr = 4'h2; prog_data = 8'h77;
      for (int i = 0; i < 3; i++) begin
         step(); expect_out("stl_frozen", 8'h10, 1'b1, 4'h1, 1'b0);
      end
      stall = 1'b0; prog_we = 1'b0;
      step(); expect_out("stl_i1", 8'h20, 1'b1, 4'h2, 1'b0);
      step(); expect_out("stl_no_write", 8'h30, 1'b1, 4'h3, 1'b0);
      step(); expect_out("stl_i3", 8'h40, 1'b1, 4'h4, 1'b0);
      stall = 1'b1;
      step(); expect_out("stl_on_halt", 8'h40, 1'b1, 4'h4, 1'b0);
      stall = 1'b0;
      step(); expect_out("stl_halt", 8'h00, 1'b0, 4'h4, 1'b1);

      // PC wrap with all-ordinary program, then mid-run reset
      for (int i = 0; i < 16; i++) load(i[3:0], 8'h10);
      start = 1'b1; step(); start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         logic [4:0] kk;
         kk = k[4:0];
         step(); expect_out("wrap", 8'h10, 1'b1, kk[3:0], 1'b0);
      end
      do_reset();
      expect_out("mid_rst", 8'h00, 1'b0, 4'h0, 1'b0);

      // Simultaneous start and write to START_PC: first fetch sees new word
      start = 1'b1; prog_we = 1'b1; prog_addr = 4'h0; prog_data = 8'hF0;
      step();
      start = 1'b0; prog_we = 1'b0;
      expect_out("sw_start", 8'h00, 1'b0, 4'h0, 1'b0);
      step(); expect_out("sw_halt", 8'h00, 1'b0, 4'h0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
